event_scheduler: RTL and testbench

EVENT_SCHEDULER -- requirements
Module: event_scheduler

---
 rtl/event_scheduler_pkg.sv | 18 +
 rtl/event_scheduler_if.sv | 26 ++
 rtl/event_fifo.sv | 54 +++++
 rtl/event_scheduler.sv | 165 ++++++++++++++++
 tb/tb_event_scheduler.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/event_scheduler_pkg.sv
// Shared types for the event scheduler: output FSM encoding, code type and
// requester indices used by the arbiter.
package event_scheduler_pkg;

    localparam int CODE_W = 2;
    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

    // Requester indices; the round-robin pointer holds the favoured one.
    localparam int REQ_ROT = 0;
    localparam int REQ_TMR = 1;

endpackage

// File: rtl/event_scheduler_if.sv
// Request/response bundle between the event sources, the scheduler and the
// downstream processor. master = environment side, slave = scheduler side.
interface event_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    import event_scheduler_pkg::*;

    logic                        rotation_event;
    code_t                       sw;
    logic                        tick_en;
    logic                        y_ready;
    code_t                       y_out;
    logic                        y_valid;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;

    modport master (
        output rotation_event, sw, tick_en, y_ready,
        input  y_out, y_valid, fifo_count, overflow
    );

    modport slave (
        input  rotation_event, sw, tick_en, y_ready,
        output y_out, y_valid, fifo_count, overflow
    );
endinterface

// File: rtl/event_fifo.sv
// Circular code queue with occupancy count; push and pop may coincide,
// including push while full when a pop frees the slot in the same edge.
module event_fifo
    import event_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  code_t                  din_i,
    input  logic                   pop_i,
    output code_t                  dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    code_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  cnt_q;
    logic           do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/event_scheduler.sv
// Event scheduler top: pending request slots, round-robin arbiter into the
// event FIFO, and a registered output stage with valid/ready handshake.
// Optional auto-step timer (requester 1) when EVENT_SCHEDULER_TIMER_EN is defined.
module event_scheduler
    import event_scheduler_pkg::*;
#(
    parameter int          AUTO_PERIOD = 25000000,
    parameter logic [1:0]  TIMER_CODE  = 2'b01,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    event_scheduler_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e         state_q;
    code_t          y_out_q;
    logic           y_valid_q;

    logic           p0_q, p0_d;
    code_t          c0_q, c0_d;
    logic           ovf_q, ovf_d;
    logic           gnt0, gnt1;
    logic           push, pop;
    code_t          push_code;
    code_t          fifo_dout;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_cnt;

`ifdef EVENT_SCHEDULER_TIMER_EN
    localparam int TW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;

    logic           p1_q, p1_d;
    logic           rr_q, rr_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           wrap;

    assign wrap = bus.tick_en && (tmr_q == TW'(AUTO_PERIOD - 1));

    always_comb begin
        tmr_d = tmr_q + 1'b1;
        if (!bus.tick_en || wrap) tmr_d = '0;
    end

    // Both pending: the pointer decides; otherwise whichever slot is full.
    assign gnt0 = !fifo_full && p0_q && (!p1_q || rr_q == 1'(REQ_ROT));
    assign gnt1 = !fifo_full && p1_q && (!p0_q || rr_q == 1'(REQ_TMR));
    assign push_code = gnt0 ? c0_q : code_t'(TIMER_CODE);

    always_comb begin
        rr_d = rr_q;
        if (gnt0) rr_d = 1'(REQ_TMR);
        if (gnt1) rr_d = 1'(REQ_ROT);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.tick_en, TIMER_CODE, AUTO_PERIOD[0]};

    assign gnt0      = !fifo_full && p0_q;
    assign gnt1      = 1'b0;
    assign push_code = c0_q;
`endif

    assign push = gnt0 || gnt1;

    // A slot that is full when a new request lands drops the request, even
    // if the slot is being granted on the same edge.
    always_comb begin
        p0_d  = p0_q;
        c0_d  = c0_q;
        ovf_d = ovf_q;
        if (gnt0) p0_d = 1'b0;
        if (bus.rotation_event) begin
            if (p0_q) ovf_d = 1'b1;
            else begin
                p0_d = 1'b1;
                c0_d = bus.sw;
            end
        end
`ifdef EVENT_SCHEDULER_TIMER_EN
        p1_d = p1_q;
        if (gnt1) p1_d = 1'b0;
        if (wrap) begin
            if (p1_q) ovf_d = 1'b1;
            else      p1_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_q  <= 1'b0;
            c0_q  <= '0;
            ovf_q <= 1'b0;
`ifdef EVENT_SCHEDULER_TIMER_EN
            p1_q  <= 1'b0;
            rr_q  <= 1'(REQ_ROT);
            tmr_q <= '0;
`endif
        end else begin
            p0_q  <= p0_d;
            c0_q  <= c0_d;
            ovf_q <= ovf_d;
`ifdef EVENT_SCHEDULER_TIMER_EN
            p1_q  <= p1_d;
            rr_q  <= rr_d;
            tmr_q <= tmr_d;
`endif
        end
    end

    assign pop = (state_q == ST_LOAD) ||
                 (state_q == ST_PRESENT && bus.y_ready && !fifo_empty);

    event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_code),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    y_out_q   <= fifo_dout;
                    y_valid_q <= 1'b1;
                    state_q   <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (bus.y_ready) begin
                        if (!fifo_empty) y_out_q <= fifo_dout;
                        else begin
                            y_valid_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    y_valid_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.y_out      = y_out_q;
    assign bus.y_valid    = y_valid_q;
    assign bus.fifo_count = fifo_cnt;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_event_scheduler.sv
// Self-checking bench for event_scheduler: directed scenarios plus random
// traffic against a queue-based reference model (timer-aware when
// EVENT_SCHEDULER_TIMER_EN is defined).
module tb_event_scheduler;
    localparam int         AP    = 4;
    localparam logic [1:0] TCODE = 2'b01;
    localparam int         DEPTH = 4;
    localparam int         CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec  = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    event_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

    event_scheduler #(
        .AUTO_PERIOD (AP),
        .TIMER_CODE  (TCODE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: queue of codes, two request slots, favoured slot,
    // plain timer count and a three-phase output stage.
    logic [1:0] m_q[$];
    bit         m_p0, m_p1, m_fav, m_ovf, m_valid, m_loading;
    logic [1:0] m_c0, m_out;
    int         m_tmr;

    function automatic void m_reset();
        m_q.delete();
        m_p0 = 0; m_p1 = 0; m_fav = 0; m_ovf = 0;
        m_valid = 0; m_loading = 0; m_c0 = 0; m_out = 0; m_tmr = 0;
    endfunction

    function automatic void m_step(bit rot, logic [1:0] swv, bit tick, bit rdy);
        int         n    = m_q.size();
        bit         pop  = 0;
        bit         g0   = 0, g1 = 0;
        bit         wrap = 0;
        bit         p0_pre = m_p0, p1_pre = m_p1;
        logic [1:0] head = (n > 0) ? m_q[0] : 2'b00;
        if (m_loading) begin
            m_out = head; m_valid = 1; m_loading = 0; pop = 1;
        end else if (m_valid) begin
            if (rdy) begin
                if (n > 0) begin m_out = head; pop = 1; end
                else m_valid = 0;
            end
        end else if (n > 0) m_loading = 1;
        if (n < DEPTH) begin
            if (m_p0 && (!m_p1 || !m_fav)) g0 = 1;
            else if (m_p1) g1 = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (g0) begin m_q.push_back(m_c0); m_p0 = 0; m_fav = 1; end
        if (g1) begin m_q.push_back(TCODE); m_p1 = 0; m_fav = 0; end
`ifdef EVENT_SCHEDULER_TIMER_EN
        wrap  = tick && (m_tmr == AP - 1);
        m_tmr = (!tick || wrap) ? 0 : m_tmr + 1;
`endif
        if (rot) begin
            if (p0_pre) m_ovf = 1;
            else begin m_p0 = 1; m_c0 = swv; end
        end
        if (wrap) begin
            if (p1_pre) m_ovf = 1;
            else m_p1 = 1;
        end
    endfunction

    task automatic tick();
        m_step(bus.rotation_event, bus.sw, bus.tick_en, bus.y_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.rotation_event = 0; bus.sw = 0; bus.tick_en = 0; bus.y_ready = 0;
        rst = 1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic pulse(logic [1:0] code);
        bus.sw = code; bus.rotation_event = 1;
        tick();
        bus.rotation_event = 0;
        tick();
    endtask

    task automatic test_reset();
        bus.rotation_event = 0; bus.sw = 0; bus.tick_en = 0; bus.y_ready = 0;
        rst = 1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        vec++; if (bus.y_valid !== 1'b0) begin errs++; $display("FAIL reset y_valid: got %b exp 0", bus.y_valid); end
        vec++; if (bus.y_out !== 2'b00) begin errs++; $display("FAIL reset y_out: got %b exp 00", bus.y_out); end
        vec++; if (bus.fifo_count !== CW'(0)) begin errs++; $display("FAIL reset fifo_count: got %0d exp 0", bus.fifo_count); end
        vec++; if (bus.overflow !== 1'b0) begin errs++; $display("FAIL reset overflow: got %b exp 0", bus.overflow); end
        rst = 0;
    endtask

    task automatic test_latency();
        do_reset();
        bus.y_ready = 1; bus.sw = 2'b10; bus.rotation_event = 1;
        tick();
        bus.rotation_event = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vec++;
            if (bus.y_valid !== (k == 3)) begin
                errs++; $display("FAIL latency y_valid k=%0d: got %b exp %b", k, bus.y_valid, (k == 3));
            end
            if (k == 3) begin
                vec++;
                if (bus.y_out !== 2'b10) begin errs++; $display("FAIL latency y_out: got %b exp 10", bus.y_out); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] seq[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] exp_d[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [1:0] got[$];
        do_reset();
        foreach (seq[i]) pulse(seq[i]);
        repeat (2) tick();
        vec++; if (bus.fifo_count !== CW'(4)) begin errs++; $display("FAIL bp fifo_count: got %0d exp 4", bus.fifo_count); end
        vec++; if (bus.y_valid !== 1'b1 || bus.y_out !== 2'd0) begin
            errs++; $display("FAIL bp head: got v=%b y=%0d exp v=1 y=0", bus.y_valid, bus.y_out);
        end
        vec++; if (bus.overflow !== 1'b0) begin errs++; $display("FAIL bp overflow early: got %b exp 0", bus.overflow); end
        pulse(2'd1);
        pulse(2'd2);
        vec++; if (bus.overflow !== 1'b1) begin errs++; $display("FAIL bp overflow set: got %b exp 1", bus.overflow); end
        vec++; if (bus.fifo_count !== CW'(4)) begin errs++; $display("FAIL bp held count: got %0d exp 4", bus.fifo_count); end
        bus.y_ready = 1;
        repeat (20) begin
            if (bus.y_valid) got.push_back(bus.y_out);
            tick();
        end
        vec++; if (got.size() != 6) begin errs++; $display("FAIL bp drain length: got %0d exp 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            vec++;
            if (got[i] !== exp_d[i]) begin errs++; $display("FAIL bp drain[%0d]: got %0d exp %0d", i, got[i], exp_d[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(2'd1); pulse(2'd2); pulse(2'd3); pulse(2'd1);
        repeat (2) tick();
        vec++; if (bus.y_valid !== 1'b1 || bus.fifo_count !== CW'(3)) begin
            errs++; $display("FAIL rstmid setup: got v=%b cnt=%0d exp v=1 cnt=3", bus.y_valid, bus.fifo_count);
        end
        #1 rst = 1;
        m_reset();
        #1;
        vec++; if (bus.y_valid !== 1'b0 || bus.fifo_count !== CW'(0) || bus.y_out !== 2'b00) begin
            errs++; $display("FAIL rstmid async: got v=%b cnt=%0d y=%0d exp 0/0/0", bus.y_valid, bus.fifo_count, bus.y_out);
        end
        #1 rst = 0;
        bus.y_ready = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vec++;
            if (bus.y_valid !== 1'b0) begin errs++; $display("FAIL rstmid stale k=%0d: got v=%b exp 0", k, bus.y_valid); end
        end
    endtask

`ifdef EVENT_SCHEDULER_TIMER_EN
    task automatic test_collision();
        logic [1:0] exp_c[5] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b00};
        logic [1:0] got[$];
        do_reset();
        bus.y_ready = 1;
        for (int t = 1; t <= 24; t++) begin
            if (bus.y_valid) got.push_back(bus.y_out);
            bus.tick_en        = (t <= 8);
            bus.rotation_event = (t == 4 || t == 6 || t == 8);
            bus.sw             = (t == 4) ? 2'b11 : (t == 6) ? 2'b10 : 2'b00;
            tick();
        end
        bus.rotation_event = 0; bus.tick_en = 0;
        vec++; if (got.size() != 5) begin errs++; $display("FAIL collide length: got %0d exp 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            vec++;
            if (got[i] !== exp_c[i]) begin errs++; $display("FAIL collide[%0d]: got %b exp %b", i, got[i], exp_c[i]); end
        end
    endtask
`else
    task automatic test_no_timer();
        do_reset();
        bus.tick_en = 1; bus.y_ready = 1;
        for (int k = 0; k < 100; k++) begin
            tick();
            vec++;
            if (bus.y_valid !== 1'b0 || bus.fifo_count !== CW'(0)) begin
                errs++; $display("FAIL notimer k=%0d: got v=%b cnt=%0d exp 0/0", k, bus.y_valid, bus.fifo_count);
            end
        end
        bus.tick_en = 0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.rotation_event = ($urandom_range(0, 2) == 0);
            bus.sw             = 2'($urandom);
            bus.tick_en        = ($urandom_range(0, 3) != 0);
            bus.y_ready        = ($urandom_range(0, 2) != 0);
            tick();
            vec++;
            if (bus.y_valid !== m_valid || bus.y_out !== m_out ||
                bus.fifo_count !== CW'(m_q.size()) || bus.overflow !== m_ovf) begin
                errs++;
                $display("FAIL random cyc %0d: got v=%b y=%0d cnt=%0d ovf=%b exp v=%b y=%0d cnt=%0d ovf=%b",
                         k, bus.y_valid, bus.y_out, bus.fifo_count, bus.overflow,
                         m_valid, m_out, m_q.size(), m_ovf);
            end
        end
        bus.rotation_event = 0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_reset_mid();
`ifdef EVENT_SCHEDULER_TIMER_EN
        test_collision();
`else
        test_no_timer();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
